// File: rtl/piso_defs_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter: FSM state encodings and logic constants.
// The PARITY encoding is only entered when the top is built with PISO_PARITY_EN defined.
package piso_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } piso_state_t;

    localparam logic LOGIC_FALSE = 1'b0;
    localparam logic LOGIC_TRUE  = 1'b1;

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit-position counter for the serialiser: async reset, sync clear, saturates at WIDTH-1.
// term flags the last bit position so the top can end or chain the frame.
module piso_bit_cnt
    import piso_defs::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic term
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LAST)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign term = (cnt == LAST) ? LOGIC_TRUE : LOGIC_FALSE;

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register, MSB first, with a ready/load handshake and back-to-back streaming.
// Define PISO_PARITY_EN to append an even-parity bit (flagged on PAR) after each word.
module piso_shift_reg
    import piso_defs::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] D,
    input  logic             LD,
    output logic             RDY,
    output logic             Q,
    output logic             nQ,
    output logic             VLD,
    output logic             PAR
);

    piso_state_t      state;
    logic [WIDTH-1:0] shreg;
    logic             q_r;
    logic             vld_r;
    logic             last;
    logic             rdy;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_inc;
`ifdef PISO_PARITY_EN
    logic             par_r;
    logic             par_bit;
`endif

    // A new word may enter when idle or in the final cycle of the current frame.
    always_comb begin
        rdy = LOGIC_FALSE;
        case (state)
            ST_IDLE:   rdy = LOGIC_TRUE;
`ifdef PISO_PARITY_EN
            ST_PARITY: rdy = LOGIC_TRUE;
`else
            ST_SHIFT:  rdy = last;
`endif
            default:   rdy = LOGIC_FALSE;
        endcase
        if (R) begin
            rdy = LOGIC_FALSE;
        end
    end

    assign accept  = LD & rdy;
    assign cnt_clr = accept | ((state == ST_SHIFT) & last);
    assign cnt_inc = (state == ST_SHIFT) & ~last;

    piso_bit_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_cnt (
        .clk  (C),
        .rst  (R),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .term (last)
    );

    // MSB goes straight to Q on accept; shreg keeps the remaining bits left-aligned.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            q_r     <= LOGIC_FALSE;
            vld_r   <= LOGIC_FALSE;
`ifdef PISO_PARITY_EN
            par_r   <= LOGIC_FALSE;
            par_bit <= LOGIC_FALSE;
`endif
        end else if (accept) begin
            state   <= ST_SHIFT;
            shreg   <= {D[WIDTH-2:0], 1'b0};
            q_r     <= D[WIDTH-1];
            vld_r   <= LOGIC_TRUE;
`ifdef PISO_PARITY_EN
            par_r   <= LOGIC_FALSE;
            par_bit <= ^D;
`endif
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (!last) begin
                        q_r   <= shreg[WIDTH-1];
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                    end else begin
`ifdef PISO_PARITY_EN
                        state <= ST_PARITY;
                        q_r   <= par_bit;
                        par_r <= LOGIC_TRUE;
`else
                        state <= ST_IDLE;
                        q_r   <= LOGIC_FALSE;
                        vld_r <= LOGIC_FALSE;
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                ST_PARITY: begin
                    state <= ST_IDLE;
                    q_r   <= LOGIC_FALSE;
                    vld_r <= LOGIC_FALSE;
                    par_r <= LOGIC_FALSE;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign RDY = rdy;
    assign Q   = q_r;
    assign nQ  = ~q_r;
    assign VLD = vld_r;
`ifdef PISO_PARITY_EN
    assign PAR = par_r;
`else
    assign PAR = LOGIC_FALSE;
`endif

endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg: frame-queue reference model checked every cycle, plus directed literal checks.
// Builds with or without PISO_PARITY_EN.
module tb_piso_shift_reg;

    logic       C = 1'b0;
    logic       R = 1'b1;
    logic       LD = 1'b0;
    logic [7:0] D = 8'h00;
    logic       RDY, Q, nQ, VLD, PAR;

    logic       LD2 = 1'b0;
    logic [1:0] D2 = 2'b00;
    logic       RDY2, Q2, nQ2, VLD2, PAR2;
    logic [1:0] sipo;

    int n_tests = 0;
    int n_fail  = 0;

    piso_shift_reg #(.WIDTH(8)) dut (
        .C(C), .R(R), .D(D), .LD(LD), .RDY(RDY), .Q(Q), .nQ(nQ), .VLD(VLD), .PAR(PAR)
    );

    piso_shift_reg #(.WIDTH(2)) dut2 (
        .C(C), .R(R), .D(D2), .LD(LD2), .RDY(RDY2), .Q(Q2), .nQ(nQ2), .VLD(VLD2), .PAR(PAR2)
    );

    always #5 C = ~C;

    // Serial-in receiver for the WIDTH=2 loopback.
    always @(posedge C) sipo <= {sipo[0], Q2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the bits still to appear on Q, front = bit on Q now.
    typedef struct packed {
        logic b;
        logic p;
    } ent_t;
    ent_t mq[$];

    always @(posedge C or posedge R) begin
        if (R) begin
            mq.delete();
        end else if (LD && (mq.size() <= 1)) begin
            mq.delete();
            for (int i = 7; i >= 0; i--) mq.push_back(ent_t'{b: D[i], p: 1'b0});
`ifdef PISO_PARITY_EN
            mq.push_back(ent_t'{b: ^D, p: 1'b1});
`endif
        end else if (mq.size() > 0) begin
            void'(mq.pop_front());
        end
    end

    logic ev, eb, ep, er;
    initial begin
        forever begin
            @(negedge C);
            ev = (mq.size() > 0);
            eb = ev ? mq[0].b : 1'b0;
            ep = ev ? mq[0].p : 1'b0;
            er = !R && (mq.size() <= 1);
            check("cycle{Q,nQ,VLD,PAR,RDY}", 32'({Q, nQ, VLD, PAR, RDY}), 32'({eb, ~eb, ev, ep, er}));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic ld, input logic [7:0] d);
        #1;
        LD = ld;
        D  = d;
        @(negedge C);
    endtask

    task automatic run_word(input logic [7:0] d, output logic [7:0] bits, output int vcnt);
        bits = '0;
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(i == 0, d);
            bits = {bits[6:0], Q};
            vcnt += int'(VLD);
        end
    endtask

    logic [7:0]  w8;
    logic [16:0] s17;
    int          vc;
    int          second;
    logic        orq;
    logic [1:0]  lbv [2];

    initial begin
        // Reset held with LD asserted.
        R  = 1'b1;
        LD = 1'b1;
        D  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge C);
            check("reset_outputs{Q,nQ,VLD,RDY}", 32'({Q, nQ, VLD, RDY}), 32'(4'b0100));
        end
        #1;
        R  = 1'b0;
        LD = 1'b0;
        @(negedge C);
        check("rdy_after_reset", 32'(RDY), 32'(1));

        // Single word 0xA5.
        run_word(8'hA5, w8, vc);
        check("a5_stream", 32'(w8), 32'h0A5);
        check("a5_vld_count", 32'(vc), 32'd8);
        cyc(1'b0, 8'h00);
`ifdef PISO_PARITY_EN
        check("a5_parity_cycle{VLD,PAR,Q}", 32'({VLD, PAR, Q}), 32'(3'b110));
        cyc(1'b0, 8'h00);
`endif
        check("a5_idle{VLD,Q,RDY}", 32'({VLD, Q, RDY}), 32'(3'b001));

        // Back-to-back: 0x3C accepted in the frame's final cycle.
`ifdef PISO_PARITY_EN
        second = 9;
`else
        second = 8;
`endif
        s17 = '0;
        vc  = 0;
        for (int i = 0; i <= second + 7; i++) begin
            cyc((i == 0) || (i == second), (i < second) ? 8'hA5 : 8'h3C);
            s17 = {s17[15:0], Q};
            vc += int'(VLD);
        end
`ifdef PISO_PARITY_EN
        check("b2b_stream", 32'(s17), 32'({8'hA5, 1'b0, 8'h3C}));
        check("b2b_vld_count", 32'(vc), 32'd17);
`else
        check("b2b_stream", 32'(s17[15:0]), 32'h0A53C);
        check("b2b_vld_count", 32'(vc), 32'd16);
`endif
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        check("b2b_drained_vld", 32'(VLD), 32'(0));

        // LD with 0xFF while busy on 0x00 must be ignored.
        orq = 1'b0;
        vc  = 0;
        cyc(1'b1, 8'h00);
        orq |= Q; vc += int'(VLD);
        cyc(1'b0, 8'h00);
        orq |= Q; vc += int'(VLD);
        for (int i = 0; i < 5; i++) begin
            check("busy_rdy_low", 32'(RDY), 32'(0));
            cyc(1'b1, 8'hFF);
            orq |= Q; vc += int'(VLD);
        end
        cyc(1'b0, 8'h00);
        orq |= Q; vc += int'(VLD);
        check("busy_word_all_zero", 32'(orq), 32'(0));
        check("busy_word_vld_count", 32'(vc), 32'd8);
        cyc(1'b0, 8'h00);
`ifdef PISO_PARITY_EN
        cyc(1'b0, 8'h00);
`endif
        check("ff_not_emitted_vld", 32'(VLD), 32'(0));
        run_word(8'hFF, w8, vc);
        check("ff_represented_stream", 32'(w8), 32'h0FF);

        // Drain, then async reset in the middle of 0xFF.
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00);
        check("pre_reset_q_high", 32'({Q, VLD}), 32'(2'b11));
        #2;
        R = 1'b1;
        #1;
        check("async_reset{Q,nQ,VLD,RDY}", 32'({Q, nQ, VLD, RDY}), 32'(4'b0100));
        @(negedge C);
        #1;
        R = 1'b0;
        @(negedge C);
        check("post_reset{RDY,VLD,Q}", 32'({RDY, VLD, Q}), 32'(3'b100));
        vc = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 8'h00);
            vc += int'(VLD);
        end
        check("no_residual_bits", 32'(vc), 32'd0);

`ifdef PISO_PARITY_EN
        // Parity bit for 0x07 (three ones) is 1.
        run_word(8'h07, w8, vc);
        check("p07_stream", 32'(w8), 32'h007);
        cyc(1'b0, 8'h00);
        check("p07_parity{Q,PAR,VLD}", 32'({Q, PAR, VLD}), 32'(3'b111));
        cyc(1'b0, 8'h00);
`endif

        // WIDTH=2 loopback into a 2-bit serial-in register.
        lbv[0] = 2'b10;
        lbv[1] = 2'b01;
        for (int k = 0; k < 2; k++) begin
            #1;
            LD2 = 1'b1;
            D2  = lbv[k];
            @(negedge C);
            check("lb_first{Q,nQ,VLD,PAR}", 32'({Q2, nQ2, VLD2, PAR2}),
                  32'({lbv[k][1], ~lbv[k][1], 1'b1, 1'b0}));
            #1;
            LD2 = 1'b0;
            @(negedge C);
            @(negedge C);
            check("lb_sipo", 32'(sipo), 32'(lbv[k]));
            check("lb_rdy", 32'(RDY2), 32'(1));
            @(negedge C);
            @(negedge C);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
